// File: rtl/mode_processing.sv
// Six-mode cyclic sequencer with a flicker option that bounces between
// modes 2 and 3. The mode output comes straight from the state register.
module mode_processing (
    input  logic       check,
    input  logic       rst,
    input  logic       flick,
    input  logic [2:0] prev_mode,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } mode_t;

    mode_t state_q;
    mode_t state_d;

    // prev_mode is a reserved status input and deliberately does not steer the sequence.
    logic unused_prev_mode;
    assign unused_prev_mode = ^prev_mode;

    // State register: cleared the instant rst drops, otherwise advances on each check edge.
    always_ff @(posedge check or negedge rst) begin
        if (!rst) begin
            state_q <= M0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-mode selection: count 0..5 with wrap; flick turns 3 back to 2; 6/7 recover to 0.
    always_comb begin
        state_d = M0;
        case (state_q)
            M0:      state_d = M1;
            M1:      state_d = M2;
            M2:      state_d = M3;
            M3:      state_d = flick ? M2 : M4;
            M4:      state_d = M5;
            M5:      state_d = M0;
            default: state_d = M0;
        endcase
    end

    assign mode = state_q;

endmodule

// File: tb/tb_mode_processing.sv
// Directed bench for mode_processing: counting, flicker bounce, reset behaviour,
// flick timing and prev_mode independence.
module tb_mode_processing;

    logic       check;
    logic       rst;
    logic       flick;
    logic [2:0] prev_mode;
    logic [2:0] mode;

    int n_cmp = 0;
    int n_bad = 0;

    mode_processing dut (
        .check     (check),
        .rst       (rst),
        .flick     (flick),
        .prev_mode (prev_mode),
        .mode      (mode)
    );

    // Compare one observed value against its expected value and count it.
    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full check period: rising edge, sample, falling edge, sample again.
    task automatic step(input string tag, input logic [2:0] exp);
        check = 1'b1;
        #1 chk({tag, "_rise"}, mode, exp);
        #4 check = 1'b0;
        #1 chk({tag, "_fall"}, mode, exp);
        #4;
    endtask

    // Pulse rst low with check idle, leaving mode at 0.
    task automatic do_reset();
        rst = 1'b0;
        #1 chk("reset_pulse", mode, 3'd0);
        #4 rst = 1'b1;
        #5;
    endtask

    initial begin
        logic [2:0] seq_norm [7];
        logic [2:0] seq_bounce [6];
        seq_norm   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        seq_bounce = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2};

        check = 1'b0;
        rst = 1'b0;
        flick = 1'b0;
        prev_mode = 3'd0;
        #3 chk("reset_state", mode, 3'd0);
        #7 rst = 1'b1;
        #10;

        // Normal count from reset
        for (int i = 0; i < 7; i++) step($sformatf("norm%0d", i), seq_norm[i]);

        // Async reset at mode 4 with check static, then first edge after release
        step("to2", 3'd2);
        step("to3", 3'd3);
        step("to4", 3'd4);
        rst = 1'b0;
        #1 chk("async_rst_immediate", mode, 3'd0);
        #4 rst = 1'b1;
        #5 chk("after_release_static", mode, 3'd0);
        flick = 1'b1;
        step("release_first_edge", 3'd1);

        // Flicker bounce from reset
        do_reset();
        for (int i = 0; i < 6; i++) step($sformatf("bounce%0d", i), seq_bounce[i]);

        // Flick release: 2 -> 3 under flick, then 3 -> 2, then count out, then 5 -> 0
        step("rel_to3", 3'd3);
        step("rel_3to2", 3'd2);
        flick = 1'b0;
        step("rel_n3", 3'd3);
        step("rel_n4", 3'd4);
        step("rel_n5", 3'd5);
        flick = 1'b1;
        step("rel_5to0_flick", 3'd0);

        // Flick at other modes: 1 -> 2, then reach 4 and check 4 -> 5 -> 0
        step("fl_0to1", 3'd1);
        step("fl_1to2", 3'd2);
        flick = 1'b0;
        step("fl_to3", 3'd3);
        step("fl_to4", 3'd4);
        flick = 1'b1;
        step("fl_4to5", 3'd5);
        step("fl_5to0", 3'd0);

        // Flick wiggling between edges only counts at the edge
        step("wig_to1", 3'd1);
        step("wig_to2", 3'd2);
        step("wig_to3", 3'd3);
        check = 1'b1;
        #2 flick = 1'b0;
        #1 chk("wig_hold_hi", mode, 3'd2);
        #2 check = 1'b0;
        #2 flick = 1'b1;
        #1 chk("wig_hold_lo", mode, 3'd2);
        #2;
        step("wig_edge_flick1", 3'd3);

        // Reset held low overrides check edges
        rst = 1'b0;
        #1 chk("rst_hold_entry", mode, 3'd0);
        for (int i = 0; i < 3; i++) begin
            #4 check = 1'b1;
            #1 chk($sformatf("rst_hold%0d", i), mode, 3'd0);
            #4 check = 1'b0;
        end
        #5 rst = 1'b1;
        flick = 1'b0;
        #5;

        // prev_mode independence: same normal count with prev_mode cycling
        for (int i = 0; i < 7; i++) begin
            prev_mode = 3'(i + 3);
            step($sformatf("pm%0d", i), seq_norm[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
